// File: rtl/irq_flag_ctrl.sv
// External IRQ flag controller: pin synchronisers, per-channel sense detection,
// status flags with read-before-clear, exception/DTC clears and a priority encoder.
module irq_flag_ctrl #(
    parameter  int N_IRQ       = 8,
    parameter  int SYNC_STAGES = 2,
    localparam int IDW         = $clog2(N_IRQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_IRQ-1:0]     irq_pin,
    input  logic [2*N_IRQ-1:0]   iscr,
    input  logic [N_IRQ-1:0]     ier,
    input  logic                 isr_rd,
    input  logic                 isr_wren,
    input  logic [N_IRQ-1:0]     isr_wdata,
    output logic [N_IRQ-1:0]     isr_rdata,
    input  logic                 exc_ack,
    input  logic [IDW-1:0]       exc_id,
    input  logic [N_IRQ-1:0]     disel,
    input  logic                 dtc_done,
    input  logic [IDW-1:0]       dtc_id,
    output logic [N_IRQ-1:0]     irq_req,
    output logic                 irq_vld,
    output logic [IDW-1:0]       irq_id
);

    logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q, sync_d;
    logic [N_IRQ-1:0]                  s_prev_q, s_prev_d;
    logic [N_IRQ-1:0]                  isr_q, isr_d;
    logic [N_IRQ-1:0]                  rd_mask_q, rd_mask_d;
    logic [SYNC_STAGES:0]              vld_pipe_q, vld_pipe_d;

    logic [N_IRQ-1:0] s, det, sw_clr, exc_clr, dtc_clr, clr;
    logic             edge_en;

    assign s       = sync_q[SYNC_STAGES-1];
    // Edges are only trusted once s_prev holds a real sample, so a pin held low
    // through reset does not look like a falling edge.
    assign edge_en = vld_pipe_q[SYNC_STAGES];

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], irq_pin};
        s_prev_d   = s;
        vld_pipe_d = {vld_pipe_q[SYNC_STAGES-1:0], 1'b1};
    end

    always_comb begin
        det     = '0;
        exc_clr = '0;
        dtc_clr = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            case (iscr[2*i +: 2])
                2'b00:   det[i] = ~s[i];
                2'b01:   det[i] = edge_en & s_prev_q[i] & ~s[i];
                2'b10:   det[i] = edge_en & ~s_prev_q[i] & s[i];
                default: det[i] = edge_en & (s_prev_q[i] ^ s[i]);
            endcase
            // Level mode only honours the ack once the pin has gone inactive.
            exc_clr[i] = exc_ack && (exc_id == IDW'(i)) &&
                         ((iscr[2*i +: 2] != 2'b00) || s[i]);
            dtc_clr[i] = dtc_done && (dtc_id == IDW'(i)) && disel[i];
        end
    end

    always_comb begin
        sw_clr    = isr_wren ? (~isr_wdata & rd_mask_q) : '0;
        clr       = sw_clr | exc_clr | dtc_clr;
        isr_d     = (isr_q & ~clr) | det;
        rd_mask_d = (isr_rd ? isr_q : rd_mask_q) & isr_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q     <= '1;
            s_prev_q   <= '1;
            isr_q      <= '0;
            rd_mask_q  <= '0;
            vld_pipe_q <= '0;
        end else begin
            sync_q     <= sync_d;
            s_prev_q   <= s_prev_d;
            isr_q      <= isr_d;
            rd_mask_q  <= rd_mask_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    always_comb begin
        isr_rdata = isr_q;
        irq_req   = isr_q & ier;
        irq_vld   = |irq_req;
        irq_id    = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (irq_req[i]) irq_id = IDW'(i);
        end
    end

endmodule
